// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   state_t   : run-control states (IDLE, RUN, HALTED)
//   br_mode_t : branch condition encodings
//   DEFAULT_HALT_OP : instruction word that stops fetch by default
//   branch_taken()  : evaluates a branch request against its condition
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_ZERO   = 2'b01,
    BR_NZERO  = 2'b10,
    BR_NEVER  = 2'b11
  } br_mode_t;

  localparam logic [8:0] DEFAULT_HALT_OP = 9'h1FF;

  // A branch request is taken only when its condition holds; BR_NEVER
  // suppresses the request entirely.
  function automatic logic branch_taken(input logic       branch,
                                        input logic [1:0] br_mode,
                                        input logic       alu_zero);
    logic cond;
    case (br_mode_t'(br_mode))
      BR_ALWAYS: cond = 1'b1;
      BR_ZERO:   cond = alu_zero;
      BR_NZERO:  cond = ~alu_zero;
      default:   cond = 1'b0;
    endcase
    return branch & cond;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the decode/ALU control inputs, the ROM return word and the fetch
// outputs of the sequencer.
//   slave  : the sequencer side (takes control + ROM data, drives PC/status)
//   master : the surrounding pipeline/ROM side
// Signals:
//   start, stall, branch, br_mode[1:0], br_rel, alu_zero, target[TGT_W]
//   inst_in[INST_W]   : ROM word for inst_addr
//   inst_addr, prog_ctr[PC_W], instr[INST_W], inst_valid, done,
//   inst_count[CNT_W]
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int PC_W   = 11,
  parameter int INST_W = 9,
  parameter int TGT_W  = 11,
  parameter int CNT_W  = 16
);

  logic              start;
  logic              stall;
  logic              branch;
  logic [1:0]        br_mode;
  logic              br_rel;
  logic              alu_zero;
  logic [TGT_W-1:0]  target;
  logic [INST_W-1:0] inst_in;

  logic [PC_W-1:0]   inst_addr;
  logic [PC_W-1:0]   prog_ctr;
  logic [INST_W-1:0] instr;
  logic              inst_valid;
  logic              done;
  logic [CNT_W-1:0]  inst_count;

  modport slave (
    input  start, stall, branch, br_mode, br_rel, alu_zero, target, inst_in,
    output inst_addr, prog_ctr, instr, inst_valid, done, inst_count
  );

  modport master (
    output start, stall, branch, br_mode, br_rel, alu_zero, target, inst_in,
    input  inst_addr, prog_ctr, instr, inst_valid, done, inst_count
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection.
//   pc      in  PC_W   current program counter
//   target  in  TGT_W  absolute target (zero-extended) or signed offset
//   br_rel  in  1      1 = PC-relative, 0 = absolute
//   taken   in  1      branch is taken this cycle
//   next_pc out PC_W   selected next PC, modulo 2^PC_W
// TGT_W must not exceed PC_W.
// -----------------------------------------------------------------------------
module next_pc_calc #(
  parameter int PC_W  = 11,
  parameter int TGT_W = 11
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [TGT_W-1:0] target,
  input  logic             br_rel,
  input  logic             taken,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] tgt_zext;
  logic [PC_W-1:0] tgt_sext;

  // Size-casting a signed operand replicates its sign bit.
  assign tgt_zext = PC_W'(target);
  assign tgt_sext = PC_W'(signed'(target));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_pc = pc + PC_W'(1);
    if (taken) begin
      // Adds are PC_W wide, so both directions wrap modulo 2^PC_W.
      next_pc = br_rel ? (pc + tgt_sext) : tgt_zext;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch sequencer: holds the PC, addresses a combinational
// instruction ROM, applies branches, honours stalls and stops on HALT_OP.
//   clk  in  1   clock, rising edge
//   rst  in  1   asynchronous, active-high reset
//   bus  slave   control inputs, ROM return word and fetch outputs
//                (see fetch_sequencer_if)
// inst_addr/prog_ctr are the PC; instr passes the ROM word straight through,
// so a word is valid in the same cycle as its address.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                PC_W       = 11,
  parameter int                INST_W     = 9,
  parameter int                TGT_W      = 11,
  parameter logic [PC_W-1:0]   START_ADDR = '0,
  parameter logic [INST_W-1:0] HALT_OP    = INST_W'(DEFAULT_HALT_OP),
  parameter int                CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  next_pc;
  logic             done_q;
  logic [CNT_W-1:0] count;
  logic             taken;
  logic             is_halt;

  assign taken   = branch_taken(bus.branch, bus.br_mode, bus.alu_zero);
  assign is_halt = (bus.inst_in == HALT_OP);

  next_pc_calc #(
    .PC_W  (PC_W),
    .TGT_W (TGT_W)
  ) u_next_pc (
    .pc      (pc),
    .target  (bus.target),
    .br_rel  (bus.br_rel),
    .taken   (taken),
    .next_pc (next_pc)
  );

  // NOTE: reset is in the sensitivity list so state clears the moment rst
  // rises, not at the next clock edge; inst_valid follows state and drops
  // with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= START_ADDR;
      done_q <= 1'b0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // below sees the pre-edge values of pc/count/state.
      case (state)
        RUN: begin
          // A stall freezes everything, including HALT and branch decisions.
          if (!bus.stall) begin
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
            if (is_halt) begin
              // PC stays on the HALT word; halt beats a same-cycle branch.
              state  <= HALTED;
              done_q <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end
        end
        default: begin
          // IDLE and HALTED both wait for start; start in RUN is ignored.
          if (bus.start) begin
            state  <= RUN;
            pc     <= START_ADDR;
            done_q <= 1'b0;
            count  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.inst_addr  = pc;
  assign bus.prog_ctr   = pc;
  assign bus.instr      = bus.inst_in;
  assign bus.inst_valid = (state == RUN) && !bus.stall;
  assign bus.done       = done_q;
  assign bus.inst_count = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A behavioural model tracks
// running/done flags, the PC and the issue count as plain integers and is
// compared against the DUT after every clock edge. A second instance with a
// 2-bit counter covers saturation.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int         PC_W    = 11;
  localparam int         INST_W  = 9;
  localparam int         TGT_W   = 11;
  localparam int         CNT_W   = 16;
  localparam int         PC_MOD  = 1 << PC_W;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [8:0] HALT    = 9'h1FF;
  localparam int         START   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W), .CNT_W(CNT_W)) bus ();
  fetch_sequencer_if #(.PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W), .CNT_W(2))     bus2 ();

  fetch_sequencer #(
    .PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W),
    .START_ADDR(11'd0), .HALT_OP(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fetch_sequencer #(
    .PC_W(PC_W), .INST_W(INST_W), .TGT_W(TGT_W),
    .START_ADDR(11'd0), .HALT_OP(HALT), .CNT_W(2)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // Combinational ROM, with an override to present an arbitrary word.
  logic [INST_W-1:0] rom [PC_MOD];
  logic              ovr_en  = 1'b0;
  logic [INST_W-1:0] ovr_val = '0;
  assign bus.inst_in  = ovr_en ? ovr_val : rom[bus.inst_addr];
  assign bus2.inst_in = '0;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state.
  bit m_run;
  bit m_done;
  int m_pc;
  int m_cnt;

  task automatic model_reset();
    m_run  = 0;
    m_done = 0;
    m_pc   = START;
    m_cnt  = 0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stall = 0; bus.branch = 0; bus.br_mode = 2'b00;
    bus.br_rel = 0; bus.alu_zero = 0; bus.target = '0;
    bus2.start = 0; bus2.stall = 0; bus2.branch = 0; bus2.br_mode = 2'b00;
    bus2.br_rel = 0; bus2.alu_zero = 0; bus2.target = '0;
    ovr_en = 0;
  endtask

  // Advance the model by one edge from the current inputs, then the clock.
  task automatic tick();
    int  ins;
    int  t;
    bit  tk;
    ins = ovr_en ? int'(ovr_val) : int'(rom[m_pc]);
    tk  = bus.branch && (bus.br_mode == 2'd0 ||
                         (bus.br_mode == 2'd1 && bus.alu_zero) ||
                         (bus.br_mode == 2'd2 && !bus.alu_zero));
    if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_done = 0; m_pc = START; m_cnt = 0;
      end
    end else if (!bus.stall) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (ins == int'(HALT)) begin
        m_run = 0; m_done = 1;
      end else if (tk && !bus.br_rel) begin
        m_pc = int'(bus.target);
      end else if (tk) begin
        t = int'(bus.target);
        if (t >= (1 << (TGT_W - 1))) t -= (1 << TGT_W);
        m_pc = ((m_pc + t) % PC_MOD + PC_MOD) % PC_MOD;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic launch();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic jump_to(input int addr);
    bus.branch = 1; bus.br_mode = 2'b00; bus.br_rel = 0; bus.target = TGT_W'(addr);
    tick();
    bus.branch = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 4;
    if (bus.prog_ctr !== 11'd0) begin n_mis++; $display("FAIL reset_pc: got %0h want 0", bus.prog_ctr); end
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", bus.done); end
    if (bus.inst_count !== 16'd0) begin n_mis++; $display("FAIL reset_count: got %0d want 0", bus.inst_count); end
    if (bus.inst_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
  endtask

  task automatic test_program();
    logic [8:0] words [4];
    words = '{9'h031, 9'h102, 9'h033, 9'h1FF};
    do_reset();
    for (int i = 0; i < PC_MOD; i++) rom[i] = '0;
    for (int i = 0; i < 4; i++) rom[i] = words[i];
    launch();
    for (int i = 0; i < 4; i++) begin
      n_cmp += 3;
      if (bus.prog_ctr !== PC_W'(i)) begin n_mis++; $display("FAIL prog_pc[%0d]: got %0d want %0d", i, bus.prog_ctr, i); end
      if (bus.instr !== words[i]) begin n_mis++; $display("FAIL prog_instr[%0d]: got %0h want %0h", i, bus.instr, words[i]); end
      if (bus.inst_valid !== 1'b1) begin n_mis++; $display("FAIL prog_valid[%0d]: got %b want 1", i, bus.inst_valid); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp += 4;
      if (bus.done !== 1'b1) begin n_mis++; $display("FAIL halt_done: got %b want 1", bus.done); end
      if (bus.prog_ctr !== 11'd3) begin n_mis++; $display("FAIL halt_pc: got %0d want 3", bus.prog_ctr); end
      if (bus.inst_count !== 16'd4) begin n_mis++; $display("FAIL halt_count: got %0d want 4", bus.inst_count); end
      if (bus.inst_valid !== 1'b0) begin n_mis++; $display("FAIL halt_valid: got %b want 0", bus.inst_valid); end
      tick();
    end
  endtask

  task automatic test_branch_cond();
    do_reset();
    for (int i = 0; i < PC_MOD; i++) rom[i] = '0;
    launch();
    repeat (5) tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd5) begin n_mis++; $display("FAIL cond_start_pc: got %0d want 5", bus.prog_ctr); end
    // BR_ZERO taken
    bus.branch = 1; bus.br_mode = 2'b01; bus.br_rel = 0; bus.target = 11'd20; bus.alu_zero = 1;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd20) begin n_mis++; $display("FAIL cond_zero_taken: got %0d want 20", bus.prog_ctr); end
    jump_to(5);
    // BR_ZERO not taken
    bus.branch = 1; bus.br_mode = 2'b01; bus.target = 11'd20; bus.alu_zero = 0;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd6) begin n_mis++; $display("FAIL cond_zero_not: got %0d want 6", bus.prog_ctr); end
    jump_to(5);
    // BR_NEVER
    bus.branch = 1; bus.br_mode = 2'b11; bus.target = 11'd20; bus.alu_zero = 1;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd6) begin n_mis++; $display("FAIL cond_never: got %0d want 6", bus.prog_ctr); end
    // BR_NZERO taken
    bus.branch = 1; bus.br_mode = 2'b10; bus.target = 11'd20; bus.alu_zero = 0;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd20) begin n_mis++; $display("FAIL cond_nzero: got %0d want 20", bus.prog_ctr); end
    idle_inputs();
  endtask

  task automatic test_branch_rel();
    do_reset();
    launch();
    jump_to(10);
    bus.branch = 1; bus.br_mode = 2'b00; bus.br_rel = 1; bus.target = 11'h7FD;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd7) begin n_mis++; $display("FAIL rel_back: got %0d want 7", bus.prog_ctr); end
    bus.target = 11'd4;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd11) begin n_mis++; $display("FAIL rel_fwd: got %0d want 11", bus.prog_ctr); end
    bus.br_rel = 0;
    jump_to(11'h7FF);
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd0) begin n_mis++; $display("FAIL inc_wrap: got %0h want 0", bus.prog_ctr); end
    bus.branch = 1; bus.br_rel = 1; bus.target = 11'h7FD;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'h7FD) begin n_mis++; $display("FAIL rel_wrap_down: got %0h want 7fd", bus.prog_ctr); end
    bus.target = 11'd5;
    tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd2) begin n_mis++; $display("FAIL rel_wrap_up: got %0h want 2", bus.prog_ctr); end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    launch();
    repeat (4) tick();
    bus.stall = 1; bus.branch = 1; bus.br_mode = 2'b00; bus.target = 11'd20;
    ovr_en = 1; ovr_val = HALT;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp += 3;
      if (bus.inst_valid !== 1'b0) begin n_mis++; $display("FAIL stall_valid[%0d]: got %b want 0", i, bus.inst_valid); end
      if (bus.prog_ctr !== 11'd4) begin n_mis++; $display("FAIL stall_pc[%0d]: got %0d want 4", i, bus.prog_ctr); end
      if (bus.inst_count !== 16'd4) begin n_mis++; $display("FAIL stall_count[%0d]: got %0d want 4", i, bus.inst_count); end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL stall_done: got %b want 0", bus.done); end
    idle_inputs();
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b1) begin n_mis++; $display("FAIL unstall_valid: got %b want 1", bus.inst_valid); end
    tick();
    n_cmp += 2;
    if (bus.prog_ctr !== 11'd5) begin n_mis++; $display("FAIL unstall_pc: got %0d want 5", bus.prog_ctr); end
    if (bus.inst_count !== 16'd5) begin n_mis++; $display("FAIL unstall_count: got %0d want 5", bus.inst_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    launch();
    repeat (5) tick();
    bus.start = 1;
    tick();
    bus.start = 0;
    n_cmp += 2;
    if (bus.prog_ctr !== 11'd6) begin n_mis++; $display("FAIL start_in_run_pc: got %0d want 6", bus.prog_ctr); end
    if (bus.inst_count !== 16'd6) begin n_mis++; $display("FAIL start_in_run_count: got %0d want 6", bus.inst_count); end
    repeat (3) tick();
    n_cmp++;
    if (bus.prog_ctr !== 11'd9) begin n_mis++; $display("FAIL pre_reset_pc: got %0d want 9", bus.prog_ctr); end
    #2;
    rst = 1;
    #1;
    n_cmp += 4;
    if (bus.prog_ctr !== 11'd0) begin n_mis++; $display("FAIL async_pc: got %0d want 0", bus.prog_ctr); end
    if (bus.inst_valid !== 1'b0) begin n_mis++; $display("FAIL async_valid: got %b want 0", bus.inst_valid); end
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL async_done: got %b want 0", bus.done); end
    if (bus.inst_count !== 16'd0) begin n_mis++; $display("FAIL async_count: got %0d want 0", bus.inst_count); end
    #1;
    rst = 0;
    model_reset();
    tick();
    n_cmp += 2;
    if (bus.prog_ctr !== 11'd0) begin n_mis++; $display("FAIL post_reset_pc: got %0d want 0", bus.prog_ctr); end
    if (bus.inst_valid !== 1'b0) begin n_mis++; $display("FAIL post_reset_idle: got %b want 0", bus.inst_valid); end
  endtask

  task automatic test_restart();
    do_reset();
    launch();
    repeat (2) tick();
    ovr_en = 1; ovr_val = HALT;
    tick();
    ovr_en = 0;
    repeat (2) tick();
    n_cmp += 3;
    if (bus.done !== 1'b1) begin n_mis++; $display("FAIL restart_pre_done: got %b want 1", bus.done); end
    if (bus.prog_ctr !== 11'd2) begin n_mis++; $display("FAIL restart_pre_pc: got %0d want 2", bus.prog_ctr); end
    if (bus.inst_count !== 16'd3) begin n_mis++; $display("FAIL restart_pre_count: got %0d want 3", bus.inst_count); end
    launch();
    n_cmp += 4;
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL restart_done: got %b want 0", bus.done); end
    if (bus.prog_ctr !== 11'd0) begin n_mis++; $display("FAIL restart_pc: got %0d want 0", bus.prog_ctr); end
    if (bus.inst_count !== 16'd0) begin n_mis++; $display("FAIL restart_count: got %0d want 0", bus.inst_count); end
    if (bus.inst_valid !== 1'b1) begin n_mis++; $display("FAIL restart_valid: got %b want 1", bus.inst_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < PC_MOD; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? HALT : INST_W'($urandom_range(0, 9'h1FE));
    for (int c = 0; c < 3000; c++) begin
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.branch   = ($urandom_range(0, 2) == 0);
      bus.br_mode  = 2'($urandom_range(0, 3));
      bus.br_rel   = 1'($urandom_range(0, 1));
      bus.alu_zero = 1'($urandom_range(0, 1));
      bus.target   = TGT_W'($urandom_range(0, PC_MOD - 1));
      tick();
      n_cmp += 5;
      if (bus.prog_ctr !== PC_W'(m_pc)) begin n_mis++; $display("FAIL rnd_pc@%0d: got %0d want %0d", c, bus.prog_ctr, m_pc); end
      if (bus.done !== m_done) begin n_mis++; $display("FAIL rnd_done@%0d: got %b want %b", c, bus.done, m_done); end
      if (bus.inst_count !== CNT_W'(m_cnt)) begin n_mis++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, bus.inst_count, m_cnt); end
      if (bus.inst_valid !== (m_run && !bus.stall)) begin n_mis++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.inst_valid, m_run && !bus.stall); end
      if (bus.instr !== rom[m_pc]) begin n_mis++; $display("FAIL rnd_instr@%0d: got %0h want %0h", c, bus.instr, rom[m_pc]); end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    int exp_cnt;
    do_reset();
    bus2.start = 1;
    @(posedge clk); #1;
    bus2.start = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      exp_cnt = (i < 3) ? i : 3;
      n_cmp++;
      if (bus2.inst_count !== 2'(exp_cnt)) begin n_mis++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, bus2.inst_count, exp_cnt); end
    end
    n_cmp++;
    if (bus2.prog_ctr !== 11'd6) begin n_mis++; $display("FAIL sat_pc: got %0d want 6", bus2.prog_ctr); end
  endtask

  initial begin
    for (int i = 0; i < PC_MOD; i++) rom[i] = '0;
    model_reset();
    test_reset();
    test_program();
    test_branch_cond();
    test_branch_rel();
    test_stall();
    test_async_reset();
    test_restart();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised instruction-fetch sequencer.
- Holds the program counter and drives the instruction-memory address. Receives the fetched word back from the combinational instruction ROM.
- Applies absolute or PC-relative, conditional or unconditional branches. Supports pipeline stall.
- Run control: Start launches a program; a HALT opcode stops it and raises Done.
- Sits between the control/ALU stage and the instruction ROM.

Parameters:
- PC_W, 11, program counter / instruction address width.
- INST_W, 9, instruction word width.
- TGT_W, 11, branch target/offset width (must be ≤ PC_W).
- START_ADDR, 0, PC value loaded on reset and on Start.
- HALT_OP, 9'h1FF, instruction word that halts fetch.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- Clk  in  1  clock, posedge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  launch program; sampled in IDLE or HALTED only.
- Stall  in  1  hold PC this cycle.
- Branch  in  1  branch request from decode.
- BrMode  in  2  00 always, 01 if AluZero, 10 if !AluZero, 11 never.
- BrRel  in  1  1 = PC-relative signed offset; 0 = absolute target.
- AluZero  in  1  ALU zero flag.
- Target  in  TGT_W  absolute target or signed offset.
- InstIn  in  INST_W  word returned by ROM for InstAddr.
- InstAddr  out  PC_W  ROM address, equal to ProgCtr.
- ProgCtr  out  PC_W  current PC.
- Instr  out  INST_W  equal to InstIn, combinational.
- InstValid  out  1  high when state==RUN and Stall==0.
- Done  out  1  registered; high in HALTED.
- InstCount  out  CNT_W  number of instructions issued since last Start; saturating.

Behaviour:
- Reset (async, any time, including mid-run):
  - state=IDLE, ProgCtr=START_ADDR, Done=0, InstCount=0.
  - InstValid=0 immediately.
- States and transitions:
  - IDLE: PC held. Start=1 → RUN next edge, with PC=START_ADDR and InstCount=0.
  - RUN, Stall=1: PC, state and InstCount are held. Branch and HALT detection are ignored; stall wins.
  - RUN, Stall=0, InstIn==HALT_OP: → HALTED, PC held at the HALT address, Done=1 from the next edge. The HALT word is counted. Halt wins over a same-cycle Branch.
  - RUN, Stall=0, taken branch: taken = Branch & (BrMode==00 | (BrMode==01 & AluZero) | (BrMode==10 & !AluZero)).
    - BrRel=0: next PC = zero-extended Target.
    - BrRel=1: next PC = PC + sign-extended Target.
  - RUN, Stall=0, otherwise: next PC = PC + 1.
  - Every non-stalled RUN cycle increments InstCount. InstCount saturates at 2^CNT_W-1.
  - HALTED: everything held, Done=1. Start=1 → RUN with PC=START_ADDR, Done=0, InstCount=0.
- Start in RUN is ignored.
- All PC arithmetic is modulo 2^PC_W:
  - Increment from all-ones wraps to 0.
  - Relative branches wrap in both directions.
- Latency:
  - New PC is visible one cycle after the decision edge.
  - Instr is valid in the same cycle as its ProgCtr; no registered fetch stage.
- BrMode=11 never branches, even with Branch=1; the PC increments.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, HALTED}.
  - BrMode encodings: BR_ALWAYS, BR_ZERO, BR_NZERO, BR_NEVER.
  - Default HALT_OP constant.
- Sub-module next_pc_calc: combinational.
  - Inputs: PC, Target, BrRel, taken.
  - Output: next PC.
  - Performs sign/zero extension and modulo add.
- The state register, counter and run control stay in fetch_sequencer.

Test Plan:
- Reset then Start pulse with ROM {0:9'h031, 1:9'h102, 2:9'h033, 3:9'h1FF} → ProgCtr sequence 0,1,2,3.
  - Done=1 the cycle after PC=3; PC stays 3; InstCount=4.
- At PC=5: Branch=1, BrMode=01, BrRel=0, Target=20. With AluZero=1 → next PC=20. With AluZero=0 → next PC=6. BrMode=11 → next PC=6.
- At PC=10: BrRel=1, Target=11'h7FD (−3), BrMode=00 → next PC=7.
  - At PC=11'h7FF with no branch → next PC=0 (wrap).
- Stall=1 for 3 cycles at PC=4, with Branch=1 and InstIn=HALT_OP presented → PC stays 4, InstValid=0, InstCount unchanged, state stays RUN.
- Reset asserted asynchronously mid-run at PC=9, between edges → ProgCtr=0, InstValid=0, Done=0 immediately. Start in RUN has no effect.
- In HALTED: pulse Start → Done=0 and PC=START_ADDR next edge, InstCount=0.
  - With CNT_W=2, run 6 fetches → InstCount saturates at 3.
